cl_adder: RTL and testbench

Registered 8-bit carry-lookahead adder: computes `a + b + cin` through a two-level lookahead carry network and presents the sum and carry-out on registered outputs. It is a reusable arithmetic datapath leaf, instantiated wherever a fast fixed-width add with carry-in/carry-out is needed. The carry chain is never rippled: carries come from generate/propagate terms only.

---
 rtl/cla_pkg.sv | 8 +
 rtl/cla4.sv | 22 ++
 rtl/cl_adder.sv | 55 +++++
 tb/tb_cl_adder.sv | 94 +++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// cla_pkg: shared group width and generate/propagate pair type for the lookahead adder
package cla_pkg;
  localparam int GROUP_W = 4;
  typedef struct packed {
    logic g;
    logic p;
  } gp_t;
endpackage

// File: rtl/cla4.sv
// cla4: 4-bit lookahead block producing sum bits and group generate/propagate
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       G,
  output logic       P
);
  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;
  assign g = a & b;
  assign p = a ^ b;
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign s = p ^ c;
  assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign P = &p;
endmodule

// File: rtl/cl_adder.sv
// cl_adder: registered WIDTH-bit carry-lookahead adder built from 4-bit lookahead groups
module cl_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int NG = WIDTH / GROUP_W;
  gp_t              gp [NG];
  logic [NG:0]      gc;
  logic [WIDTH-1:0] s;
  logic             acc;
  logic             term;
  for (genvar i = 0; i < NG; i++) begin : grp
    logic gi;
    logic pi;
    cla4 u_cla4 (
      .a (a[i*GROUP_W +: GROUP_W]),
      .b (b[i*GROUP_W +: GROUP_W]),
      .ci(gc[i]),
      .s (s[i*GROUP_W +: GROUP_W]),
      .G (gi),
      .P (pi)
    );
    assign gp[i] = '{g: gi, p: pi};
  end
  // group carries as flat sum-of-products over lower G/P terms and cin, never chained through gc
  always_comb begin
    gc = '0;
    acc = 1'b0;
    term = 1'b0;
    for (int k = 0; k <= NG; k++) begin
      acc = cin;
      for (int j = 0; j < k; j++) acc = acc & gp[j].p;
      for (int j = 0; j < k; j++) begin
        term = gp[j].g;
        for (int m = j + 1; m < k; m++) term = term & gp[m].p;
        acc = acc | term;
      end
      gc[k] = acc;
    end
  end
  // capture the combinational result every cycle; reset wins over new operands
  always_ff @(posedge clk) begin
    if (rst) {cout, sum} <= '0;
    else {cout, sum} <= {gc[NG], s};
  end
endmodule

// File: tb/tb_cl_adder.sv
// tb_cl_adder: scoreboard bench for cl_adder at WIDTH 8 and 16 against plain integer addition
module tb_cl_adder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  a8 = '0, b8 = '0, s8;
  logic        c8i = 1'b0, c8o;
  logic [15:0] a16 = '0, b16 = '0, s16;
  logic        c16i = 1'b0, c16o;
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [8:0]  e8;
    logic [16:0] e16;
    string       tag;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  cl_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(c8i), .sum(s8), .cout(c8o)
  );
  cl_adder #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .a(a16), .b(b16), .cin(c16i), .sum(s16), .cout(c16o)
  );

  task automatic step(input logic [7:0] x, input logic [7:0] y, input logic ci,
                      input logic r, input string tag);
    exp_t e;
    @(negedge clk);
    rst  = r;
    a8   = x;
    b8   = y;
    c8i  = ci;
    a16  = 16'($urandom);
    b16  = 16'($urandom);
    c16i = 1'($urandom_range(0, 1));
    e.e8  = r ? 9'd0 : 9'(x) + 9'(y) + 9'(ci);
    e.e16 = r ? 17'd0 : 17'(a16) + 17'(b16) + 17'(c16i);
    e.tag = tag;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks += 2;
        if ({c8o, s8} !== e.e8) begin
          failures++;
          $display("FAIL %s w8: got cout=%b sum=%h want cout=%b sum=%h",
                   e.tag, c8o, s8, e.e8[8], e.e8[7:0]);
        end
        if ({c16o, s16} !== e.e16) begin
          failures++;
          $display("FAIL %s w16: got cout=%b sum=%h want cout=%b sum=%h",
                   e.tag, c16o, s16, e.e16[16], e.e16[15:0]);
        end
      end
    end
  end

  initial begin
    step(8'hFF, 8'hFF, 1'b1, 1'b1, "reset0");
    step(8'hFF, 8'hFF, 1'b1, 1'b1, "reset1");
    step(8'hFF, 8'hFF, 1'b1, 1'b0, "reset_exit");
    step(8'h35, 8'hC1, 1'b0, 1'b0, "add_35_c1");
    step(8'h19, 8'h54, 1'b0, 1'b0, "add_19_54");
    step(8'h11, 8'h01, 1'b0, 1'b0, "add_11_01");
    step(8'h03, 8'h03, 1'b0, 1'b0, "add_03_03");
    step(8'hAA, 8'h00, 1'b0, 1'b0, "add_aa_00");
    step(8'h00, 8'h00, 1'b0, 1'b0, "add_00_00");
    step(8'hFF, 8'hFF, 1'b0, 1'b0, "carry_out");
    step(8'hF0, 8'h0F, 1'b0, 1'b0, "prop_cin0");
    step(8'hF0, 8'h0F, 1'b1, 1'b0, "prop_cin1");
    for (int i = 0; i < 8; i++)
      step(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), i == 4, "pipeline");
    for (int i = 0; i < 10000; i++)
      step(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, "random");
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
